// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared defaults and priority state type for fifo_access_arb
package fifo_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 32;

  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WR = 1'b1
  } prio_e;

endpackage

// File: rtl/fifo_access_arb_rr_arbiter.sv
// rtl/fifo_access_arb_rr_arbiter.sv - round-robin pick of the first requester at or after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Walk N positions starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      cand = sum[PW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_access_arb.sv
// rtl/fifo_access_arb.sv - arbitrates NREQ writers and one reader onto a single-op-per-cycle FIFO port
module fifo_access_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           wr_req_i,
  input  logic [NREQ-1:0][DW-1:0]   wr_data_i,
  output logic [NREQ-1:0]           wr_gnt_o,
  input  logic                      rd_req_i,
  output logic                      rd_gnt_o,
  output logic                      rd_valid_o,
  output logic [DW-1:0]             rd_data_o,
  output logic                      fifo_wr_en_o,
  output logic [DW-1:0]             fifo_wr_data_o,
  output logic                      fifo_rd_en_o,
  input  logic [DW-1:0]             fifo_rd_data_i,
  input  logic                      fifo_full_i,
  input  logic                      fifo_empty_i,
  output logic [15:0]               wr_total_o,
  output logic [15:0]               rd_total_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  prio_e           state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rd_valid_q;
  logic [15:0]     wr_total_q, rd_total_q;

  logic            wr_elig, rd_elig;
  logic            do_wr, do_rd;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;

  assign wr_elig = (|wr_req_i) && !fifo_full_i;
  assign rd_elig = rd_req_i && !fifo_empty_i;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req_i (wr_req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRI_RD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (do_rd) begin
      state_d = PRI_WR;
    end else if (do_wr) begin
      state_d = PRI_RD;
    end
  end

  // Grants are masked by rst_n so nothing reaches the FIFO while reset is held.
  always_comb begin
    do_rd = 1'b0;
    do_wr = 1'b0;
    if (rst_n) begin
      if (rd_elig && (!wr_elig || state_q == PRI_RD)) begin
        do_rd = 1'b1;
      end else if (wr_elig) begin
        do_wr = 1'b1;
      end
    end
  end

  assign wr_gnt_o       = do_wr ? arb_gnt : '0;
  assign fifo_wr_en_o   = do_wr;
  assign fifo_wr_data_o = wr_data_i[arb_idx];
  assign rd_gnt_o       = do_rd;
  assign fifo_rd_en_o   = do_rd;
  assign rd_data_o      = fifo_rd_data_i;
  assign rd_valid_o     = rd_valid_q;
  assign wr_total_o     = wr_total_q;
  assign rd_total_o     = rd_total_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (do_wr) begin
      rr_ptr_d = (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      wr_total_q <= '0;
      rd_total_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= do_rd;
      if (do_wr) wr_total_q <= wr_total_q + 16'd1;
      if (do_rd) rd_total_q <= rd_total_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_access_arb.sv
// tb/tb_fifo_access_arb.sv - directed self-checking bench for fifo_access_arb
module tb_fifo_access_arb;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        wr_req;
  logic [3:0][31:0]  wr_data;
  logic [3:0]        wr_gnt;
  logic              rd_req;
  logic              rd_gnt;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              fifo_wr_en;
  logic [31:0]       fifo_wr_data;
  logic              fifo_rd_en;
  logic [31:0]       fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [15:0]       wr_total;
  logic [15:0]       rd_total;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_access_arb #(.NREQ(4), .DW(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_req_i       (wr_req),
    .wr_data_i      (wr_data),
    .wr_gnt_o       (wr_gnt),
    .rd_req_i       (rd_req),
    .rd_gnt_o       (rd_gnt),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .fifo_wr_en_o   (fifo_wr_en),
    .fifo_wr_data_o (fifo_wr_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_full_i    (fifo_full),
    .fifo_empty_i   (fifo_empty),
    .wr_total_o     (wr_total),
    .rd_total_o     (rd_total)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req       = 4'b0000;
    rd_req       = 1'b0;
    fifo_full    = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_gnt"}, {28'h0, wr_gnt}, 32'h0);
    check({tag, "_rd_gnt"}, {31'h0, rd_gnt}, 32'h0);
    check({tag, "_wr_en"},  {31'h0, fifo_wr_en}, 32'h0);
    check({tag, "_rd_en"},  {31'h0, fifo_rd_en}, 32'h0);
  endtask

  int exp_idx [6];

  initial begin
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hA000_0000 + i;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state with active requests present: outputs forced off.
    wr_req = 4'b1111; rd_req = 1'b1; fifo_empty = 1'b0;
    next_cycle();
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_wr_total", {16'h0, wr_total}, 32'h0);
    check("rst_rd_total", {16'h0, rd_total}, 32'h0);

    // All four writers: round-robin 0,1,2,3,0.
    do_reset();
    wr_req = 4'b1111;
    exp_idx = '{0, 1, 2, 3, 0, 0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rr4_gnt%0d", c), {28'h0, wr_gnt}, 32'h1 << exp_idx[c]);
      check($sformatf("rr4_data%0d", c), fifo_wr_data, 32'hA000_0000 + exp_idx[c]);
      check($sformatf("rr4_rden%0d", c), {31'h0, fifo_rd_en}, 32'h0);
      next_cycle();
    end
    wr_req = 4'b0000;
    @(negedge clk);
    check("rr4_wr_total", {16'h0, wr_total}, 32'd5);
    check_idle_outputs("rr4_idle");

    // Sparse requesters 0 and 2 alternate.
    do_reset();
    wr_req = 4'b0101;
    exp_idx = '{0, 2, 0, 2, 0, 2};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rr2_gnt%0d", c), {28'h0, wr_gnt}, 32'h1 << exp_idx[c]);
      next_cycle();
    end
    wr_req = 4'b0000;
    @(negedge clk);
    check("rr2_wr_total", {16'h0, wr_total}, 32'd6);

    // Reader and writer both eligible: read first from reset, then alternate.
    do_reset();
    rd_req = 1'b1; wr_req = 4'b0001; fifo_empty = 1'b0; fifo_rd_data = 32'h5A5A_1234;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("alt_rd_gnt%0d", c), {31'h0, rd_gnt}, (c % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("alt_rd_en%0d", c), {31'h0, fifo_rd_en}, (c % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("alt_wr_gnt%0d", c), {28'h0, wr_gnt}, (c % 2 == 1) ? 32'h1 : 32'h0);
      check($sformatf("alt_rd_valid%0d", c), {31'h0, rd_valid}, (c % 2 == 1) ? 32'h1 : 32'h0);
      next_cycle();
    end
    rd_req = 1'b0; wr_req = 4'b0000;
    @(negedge clk);
    check("alt_rd_data", rd_data, 32'h5A5A_1234);
    check("alt_rd_total", {16'h0, rd_total}, 32'd2);
    check("alt_wr_total", {16'h0, wr_total}, 32'd2);
    check("alt_rd_valid_end", {31'h0, rd_valid}, 32'h0);

    // FIFO full: only reads granted; releasing full shows state left at PRI_WR.
    do_reset();
    fifo_full = 1'b1; wr_req = 4'b1111; rd_req = 1'b1; fifo_empty = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("full_rd_gnt%0d", c), {31'h0, rd_gnt}, 32'h1);
      check($sformatf("full_wr_gnt%0d", c), {28'h0, wr_gnt}, 32'h0);
      check($sformatf("full_wr_en%0d", c), {31'h0, fifo_wr_en}, 32'h0);
      next_cycle();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check("full_rel_wr_gnt", {28'h0, wr_gnt}, 32'h1);
    check("full_rel_rd_gnt", {31'h0, rd_gnt}, 32'h0);
    check("full_rd_total", {16'h0, rd_total}, 32'd4);
    check("full_rd_valid", {31'h0, rd_valid}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("full_next_rd_gnt", {31'h0, rd_gnt}, 32'h1);

    // FIFO empty: reads blocked.
    do_reset();
    fifo_empty = 1'b1; rd_req = 1'b1; wr_req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("empty_rd_gnt%0d", c), {31'h0, rd_gnt}, 32'h0);
      check($sformatf("empty_rd_valid%0d", c), {31'h0, rd_valid}, 32'h0);
      next_cycle();
    end
    check("empty_rd_total", {16'h0, rd_total}, 32'h0);

    // Reset asserted in the cycle after a read grant.
    do_reset();
    rd_req = 1'b1; wr_req = 4'b1111; fifo_empty = 1'b0;
    @(negedge clk);
    check("mid_rd0", {31'h0, rd_gnt}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("mid_wr1", {28'h0, wr_gnt}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("mid_rd2", {31'h0, rd_gnt}, 32'h1);
    next_cycle();
    check("mid_pre_valid", {31'h0, rd_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, rd_valid}, 32'h0);
    check_idle_outputs("mid_rst");
    check("mid_rst_wr_total", {16'h0, wr_total}, 32'h0);
    check("mid_rst_rd_total", {16'h0, rd_total}, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    rd_req = 1'b0; wr_req = 4'b1111;
    @(negedge clk);
    check("post_rst_wr_gnt", {28'h0, wr_gnt}, 32'h1);
    check("post_rst_data", fifo_wr_data, 32'hA000_0000);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_access_arb.md
FIFO_ACCESS_ARB -- requirements
Module: fifo_access_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_req, input, NREQ, per-requester write request, held until granted.
REQ-006 SHALL have port wr_data, input, NREQ x DW, per-requester write word, stable while wr_req high.
REQ-007 SHALL have port wr_gnt, output, NREQ, one-hot write grant, combinational, same cycle as fifo_wr_en.
REQ-008 SHALL have port rd_req, input, 1, consumer pop request, level.
REQ-009 SHALL have port rd_gnt, output, 1, pop accepted this cycle, combinational.
REQ-010 SHALL have port rd_valid, output, 1, rd_data valid, registered.
REQ-011 SHALL have port rd_data, output, DW, pass-through of fifo_rd_data.
REQ-012 SHALL have ports fifo_wr_en (out, 1), fifo_wr_data (out, DW), fifo_rd_en (out, 1), fifo_rd_data (in, DW), fifo_full (in, 1), fifo_empty (in, 1): single-op-per-cycle FIFO connection.
REQ-013 SHALL have ports wr_total, rd_total, output, 16 each, accepted-operation counters.

Function
REQ-014 SHALL assert at most one of fifo_wr_en, fifo_rd_en per cycle (never both).
REQ-015 Write eligible = |wr_req && !fifo_full; read eligible = rd_req && !fifo_empty.
REQ-016 Priority FSM states PRI_RD, PRI_WR: if both eligible, grant side named by state; if one eligible, grant it; none eligible, no op.
REQ-017 After a read grant state SHALL become PRI_WR; after a write grant PRI_RD; no grant, state held.
REQ-018 Write winner SHALL be chosen round-robin from pointer rr_ptr: first requesting index at or after rr_ptr, mod NREQ.
REQ-019 rr_ptr SHALL update to (winner+1) mod NREQ only on a write grant; otherwise hold.
REQ-020 On write grant to i: wr_gnt[i]=1, fifo_wr_en=1, fifo_wr_data=wr_data[i], same cycle; all other wr_gnt bits 0.
REQ-021 On read grant: rd_gnt=1, fifo_rd_en=1; rd_valid SHALL be 1 exactly in the following cycle (1-cycle latency).
REQ-022 fifo_full SHALL block all write grants; fifo_empty SHALL block read grants; blocked side does not change FSM state.
REQ-023 wr_total/rd_total SHALL increment by 1 per accepted write/read, wrapping 0xFFFF->0x0000.
REQ-024 wr_req deasserted without grant SHALL be allowed; no grant SHALL be issued to a non-requesting index.

Reset
REQ-025 While rst_n low: state PRI_RD, rr_ptr 0, rd_valid 0, wr_total 0, rd_total 0.
REQ-026 While rst_n low wr_gnt, rd_gnt, fifo_wr_en, fifo_rd_en SHALL be forced 0 combinationally.
REQ-027 Reset assertion mid-transfer SHALL drop any pending rd_valid; first grant after release follows reset state.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold NREQ/DW defaults and enum prio_e {PRI_RD, PRI_WR}.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs one-hot gnt, winner index).
REQ-030 Counters and FSM SHALL live in fifo_access_arb; no data storage other than rd_valid flag.

Verification
REQ-031 Reset, wr_req=4'b1111, full=0, rd_req=0 -> grants 0,1,2,3,0 on consecutive cycles; wr_total=5.
REQ-032 wr_req=4'b0101 continuous -> grants alternate 0,2,0,2; bits 1,3 never granted.
REQ-033 rd_req=1, wr_req=4'b0001, empty=0, full=0 from reset -> read, write, read, write; rd_valid high cycle after each read.
REQ-034 fifo_full=1, wr_req=4'b1111, rd_req=1, empty=0 -> read grant every cycle, wr_gnt=0, state toggles to PRI_WR only.
REQ-035 fifo_empty=1, rd_req=1, wr_req=0 -> no rd_gnt, rd_valid stays 0, rd_total unchanged.
REQ-036 Assert rst_n low cycle after read grant -> rd_valid 0, all enables 0 immediately; counters 0; first post-reset write grant to requester 0.
